// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI-lite N:1 arbiter: one-hot FSM encoding and limits.
package axi_arb_pkg;

    localparam int MAX_MST = 8;
    localparam int ST_NUM  = 5;
    localparam int RESP_W  = 2;
    localparam int PROT_W  = 3;

    localparam int IDLE_BIT  = 0;
    localparam int WADDR_BIT = 1;
    localparam int WRESP_BIT = 2;
    localparam int RADDR_BIT = 3;
    localparam int RDATA_BIT = 4;

    typedef enum logic [ST_NUM-1:0] {
        IDLE  = 5'b00001,
        WADDR = 5'b00010,
        WRESP = 5'b00100,
        RADDR = 5'b01000,
        RDATA = 5'b10000
    } arb_state_e;

endpackage

// File: rtl/axi_lite_arb_rr_arb.sv
// Combinational round-robin pick: first requester strictly above last_g, wrapping to 0.
module rr_arb
    import axi_arb_pkg::*;
#(
    parameter int MST_NUM     = 2,
    parameter int MST_NUM_WID = $clog2(MST_NUM)
) (
    input  logic [MST_NUM-1:0]     req,
    input  logic [MST_NUM_WID-1:0] last_g,
    output logic [MST_NUM_WID-1:0] nxt_g,
    output logic                   any
);

    logic [MAX_MST-1:0]     req_pad;
    logic [MST_NUM_WID-1:0] hi_g, lo_g;
    logic                   hi_hit, lo_hit;

    // Scan downward so the lowest index in each half wins; the upper half
    // (above last_g) takes precedence, which gives the wrap-around order.
    always_comb begin
        req_pad = MAX_MST'(req);
        hi_g    = '0;
        lo_g    = '0;
        hi_hit  = 1'b0;
        lo_hit  = 1'b0;
        for (int j = MAX_MST - 1; j >= 0; j--) begin
            if (req_pad[j] && j < MST_NUM) begin
                if (j > int'(last_g)) begin
                    hi_hit = 1'b1;
                    hi_g   = MST_NUM_WID'(j);
                end else begin
                    lo_hit = 1'b1;
                    lo_g   = MST_NUM_WID'(j);
                end
            end
        end
        nxt_g = hi_hit ? hi_g : lo_g;
        any   = hi_hit | lo_hit;
    end

endmodule

// File: rtl/axi_lite_arb.sv
// N:1 AXI-lite arbiter: round-robin grant, one transaction in flight, write beats read per master.
module axi_lite_arb
    import axi_arb_pkg::*;
#(
    parameter int MST_NUM     = 2,
    parameter int MST_NUM_WID = $clog2(MST_NUM),
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic [MST_NUM-1:0]                    mst_awvalid,
    output logic [MST_NUM-1:0]                    mst_awready,
    input  logic [MST_NUM-1:0][ADDR_W-1:0]        mst_awaddr,
    input  logic [MST_NUM-1:0][PROT_W-1:0]        mst_awprot,
    input  logic [MST_NUM-1:0]                    mst_wvalid,
    output logic [MST_NUM-1:0]                    mst_wready,
    input  logic [MST_NUM-1:0][DATA_W-1:0]        mst_wdata,
    input  logic [MST_NUM-1:0][DATA_W/8-1:0]      mst_wstrb,
    output logic [MST_NUM-1:0]                    mst_bvalid,
    input  logic [MST_NUM-1:0]                    mst_bready,
    output logic [MST_NUM-1:0][RESP_W-1:0]        mst_bresp,
    input  logic [MST_NUM-1:0]                    mst_arvalid,
    output logic [MST_NUM-1:0]                    mst_arready,
    input  logic [MST_NUM-1:0][ADDR_W-1:0]        mst_araddr,
    input  logic [MST_NUM-1:0][PROT_W-1:0]        mst_arprot,
    output logic [MST_NUM-1:0]                    mst_rvalid,
    input  logic [MST_NUM-1:0]                    mst_rready,
    output logic [MST_NUM-1:0][DATA_W-1:0]        mst_rdata,
    output logic [MST_NUM-1:0][RESP_W-1:0]        mst_rresp,

    output logic                                  slv_awvalid,
    input  logic                                  slv_awready,
    output logic [ADDR_W-1:0]                     slv_awaddr,
    output logic [PROT_W-1:0]                     slv_awprot,
    output logic                                  slv_wvalid,
    input  logic                                  slv_wready,
    output logic [DATA_W-1:0]                     slv_wdata,
    output logic [DATA_W/8-1:0]                   slv_wstrb,
    input  logic                                  slv_bvalid,
    output logic                                  slv_bready,
    input  logic [RESP_W-1:0]                     slv_bresp,
    output logic                                  slv_arvalid,
    input  logic                                  slv_arready,
    output logic [ADDR_W-1:0]                     slv_araddr,
    output logic [PROT_W-1:0]                     slv_arprot,
    input  logic                                  slv_rvalid,
    output logic                                  slv_rready,
    input  logic [DATA_W-1:0]                     slv_rdata,
    input  logic [RESP_W-1:0]                     slv_rresp
);

    arb_state_e             state, state_n;
    logic [MST_NUM_WID-1:0] g, g_n, last_g, last_g_n, nxt_g;
    logic                   aw_done, aw_done_n, w_done, w_done_n;
    logic                   any_req, aw_fin, w_fin;
    logic [MST_NUM-1:0]     req;
    logic                   st_waddr, st_wresp, st_raddr, st_rdata;

    assign req      = mst_awvalid | mst_arvalid;
    assign st_waddr = state[WADDR_BIT];
    assign st_wresp = state[WRESP_BIT];
    assign st_raddr = state[RADDR_BIT];
    assign st_rdata = state[RDATA_BIT];

    rr_arb #(
        .MST_NUM     (MST_NUM),
        .MST_NUM_WID (MST_NUM_WID)
    ) u_rr (
        .req    (req),
        .last_g (last_g),
        .nxt_g  (nxt_g),
        .any    (any_req)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            g       <= '0;
            last_g  <= MST_NUM_WID'(MST_NUM - 1);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            g       <= g_n;
            last_g  <= last_g_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // A channel counts as finished if it completed earlier or is completing now.
    assign aw_fin = aw_done | (slv_awvalid & slv_awready);
    assign w_fin  = w_done  | (slv_wvalid  & slv_wready);

    always_comb begin
        state_n   = state;
        g_n       = g;
        last_g_n  = last_g;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    g_n      = nxt_g;
                    last_g_n = nxt_g;
                    state_n  = mst_awvalid[nxt_g] ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if (aw_fin && w_fin) begin
                    state_n   = WRESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    aw_done_n = aw_fin;
                    w_done_n  = w_fin;
                end
            end
            WRESP: if (slv_bvalid && slv_bready)   state_n = IDLE;
            RADDR: if (slv_arvalid && slv_arready) state_n = RDATA;
            RDATA: if (slv_rvalid && slv_rready)   state_n = IDLE;
            default: begin
                state_n   = IDLE;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
            end
        endcase
    end

    // Downstream side: everything is gated by the owning state so IDLE drives all zeros.
    assign slv_awvalid = st_waddr & mst_awvalid[g] & ~aw_done;
    assign slv_awaddr  = st_waddr ? mst_awaddr[g] : '0;
    assign slv_awprot  = st_waddr ? mst_awprot[g] : '0;
    assign slv_wvalid  = st_waddr & mst_wvalid[g] & ~w_done;
    assign slv_wdata   = st_waddr ? mst_wdata[g] : '0;
    assign slv_wstrb   = st_waddr ? mst_wstrb[g] : '0;
    assign slv_bready  = st_wresp & mst_bready[g];
    assign slv_arvalid = st_raddr & mst_arvalid[g];
    assign slv_araddr  = st_raddr ? mst_araddr[g] : '0;
    assign slv_arprot  = st_raddr ? mst_arprot[g] : '0;
    assign slv_rready  = st_rdata & mst_rready[g];

    for (genvar m = 0; m < MST_NUM; m++) begin : g_mst
        logic sel;
        assign sel            = (g == MST_NUM_WID'(m));
        assign mst_awready[m] = st_waddr & sel & slv_awready & ~aw_done;
        assign mst_wready[m]  = st_waddr & sel & slv_wready & ~w_done;
        assign mst_bvalid[m]  = st_wresp & sel & slv_bvalid;
        assign mst_bresp[m]   = (st_wresp & sel) ? slv_bresp : '0;
        assign mst_arready[m] = st_raddr & sel & slv_arready;
        assign mst_rvalid[m]  = st_rdata & sel & slv_rvalid;
        assign mst_rdata[m]   = (st_rdata & sel) ? slv_rdata : '0;
        assign mst_rresp[m]   = (st_rdata & sel) ? slv_rresp : '0;
    end

endmodule
